// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memop encodings, FSM state type and store-mask helper
package mem_pkg;

   localparam logic [2:0] MEMOP_LB  = 3'd0;
   localparam logic [2:0] MEMOP_LH  = 3'd1;
   localparam logic [2:0] MEMOP_LW  = 3'd2;
   localparam logic [2:0] MEMOP_LD  = 3'd3;
   localparam logic [2:0] MEMOP_LBU = 3'd4;
   localparam logic [2:0] MEMOP_LHU = 3'd5;
   localparam logic [2:0] MEMOP_LWU = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_HOLD
   } state_t;

   // Byte-lane mask for a store, right-aligned; the memory port applies the address shift.
   function automatic logic [7:0] size_to_wmask(input logic [1:0] size);
      case (size)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - memory-port bundle between the mem stage and the data memory
interface mem_stage_if #(
   parameter int XLEN = 64
) ();
   logic [XLEN-1:0] raddr;
   logic [XLEN-1:0] waddr;
   logic [XLEN-1:0] wdata;
   logic [7:0]      wmask;
   logic            wvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output raddr, waddr, wdata, wmask, wvalid,
      input  rdata
   );

   modport slave (
      input  raddr, waddr, wdata, wmask, wvalid,
      output rdata
   );
endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - selects the loaded width from right-aligned read data and extends it
module load_ext
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      memop,
   output logic [XLEN-1:0] result
);

   always_comb begin
      result = '0;
      case (memop)
         MEMOP_LB:  result = {{(XLEN-8){rdata[7]}},   rdata[7:0]};
         MEMOP_LH:  result = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
         MEMOP_LW:  result = {{(XLEN-32){rdata[31]}}, rdata[31:0]};
         MEMOP_LD:  result = rdata;
         MEMOP_LBU: result = {{(XLEN-8){1'b0}},  rdata[7:0]};
         MEMOP_LHU: result = {{(XLEN-16){1'b0}}, rdata[15:0]};
         MEMOP_LWU: result = {{(XLEN-32){1'b0}}, rdata[31:0]};
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - single-entry memory pipeline stage: IDLE accepts, ACCESS touches memory, HOLD presents the result
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic            in_ren,
   input  logic            in_wen,
   input  logic [2:0]      in_memop,
   input  logic [4:0]      in_rd,
   input  logic            in_rwen,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   mem_stage_if.master     mem,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic            out_rwen,
   output logic [XLEN-1:0] out_pc
);

   state_t          state;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] pc_q;
   logic [2:0]      memop_q;
   logic [4:0]      rd_q;
   logic            wen_q;
   logic            rwen_q;
   logic            out_valid_q;
   logic            wvalid_q;
   logic [XLEN-1:0] ld_result;
   logic            accept;

   // Flush wins over everything, so nothing new enters in the cycle it is killing.
   assign in_ready = !flush && ((state == S_IDLE) || (state == S_HOLD && out_ready));
   assign accept   = in_valid && in_ready;

   load_ext #(.XLEN(XLEN)) u_load_ext (
      .rdata  (mem.rdata),
      .memop  (memop_q),
      .result (ld_result)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         pc_q        <= '0;
         memop_q     <= '0;
         rd_q        <= '0;
         wen_q       <= 1'b0;
         rwen_q      <= 1'b0;
         out_valid_q <= 1'b0;
         wvalid_q    <= 1'b0;
      end else begin
         wvalid_q <= 1'b0;
         case (state)
            S_IDLE, S_HOLD: begin
               if (flush) begin
                  state       <= S_IDLE;
                  out_valid_q <= 1'b0;
               end else if (accept) begin
                  addr_q   <= in_addr;
                  wdata_q  <= in_wdata;
                  data_q   <= in_addr;
                  pc_q     <= in_pc;
                  memop_q  <= in_memop;
                  rd_q     <= in_rd;
                  wen_q    <= in_wen;
                  rwen_q   <= in_rwen && !in_wen;
                  wvalid_q <= in_wen;
                  if (in_ren || in_wen) begin
                     state       <= S_ACCESS;
                     out_valid_q <= 1'b0;
                  end else begin
                     state       <= S_HOLD;
                     out_valid_q <= 1'b1;
                  end
               end else if (state == S_HOLD && out_ready) begin
                  state       <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            S_ACCESS: begin
               // The store pulse already happened this cycle; flush only redirects the next state.
               data_q      <= wen_q ? '0 : ld_result;
               state       <= flush ? S_IDLE : S_HOLD;
               out_valid_q <= !flush;
            end
            default: begin
               state       <= S_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem.raddr  = addr_q;
   assign mem.waddr  = addr_q;
   assign mem.wdata  = wdata_q;
   assign mem.wmask  = size_to_wmask(memop_q[1:0]);
   assign mem.wvalid = wvalid_q;

   assign out_valid = out_valid_q;
   assign out_data  = data_q;
   assign out_rd    = rd_q;
   assign out_rwen  = rwen_q;
   assign out_pc    = pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;
   import mem_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_addr = '0;
   logic [63:0] in_wdata = '0;
   logic        in_ren = 1'b0;
   logic        in_wen = 1'b0;
   logic [2:0]  in_memop = '0;
   logic [4:0]  in_rd = '0;
   logic        in_rwen = 1'b0;
   logic [63:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        out_rwen;
   logic [63:0] out_pc;

   logic        use_fixed = 1'b0;
   logic [63:0] fixed_rdata = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit rand_en = 1'b0;

   mem_stage_if #(.XLEN(64)) mif ();

   function automatic logic [63:0] rd_fn(input logic [63:0] a);
      return {a[31:0] ^ 32'h9E3779B9, a[31:0] * 32'h85EBCA6B};
   endfunction

   // Reference load: keep the low 8*2^size bits, sign-fill above them for the signed opcodes.
   function automatic logic [63:0] ld_model(input logic [63:0] r, input logic [2:0] op);
      int nb;
      logic [63:0] m;
      logic [63:0] v;
      if (op == 3'd7) return 64'd0;
      nb = 8 * (1 << op[1:0]);
      m  = (nb == 64) ? {64{1'b1}} : ((64'd1 << nb) - 64'd1);
      v  = r & m;
      if (op < 3'd4 && v[nb-1]) v = v | ~m;
      return v;
   endfunction

   assign mif.rdata = use_fixed ? fixed_rdata : rd_fn(mif.raddr);

   mem_stage #(.XLEN(64)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_wdata  (in_wdata),
      .in_ren    (in_ren),
      .in_wen    (in_wen),
      .in_memop  (in_memop),
      .in_rd     (in_rd),
      .in_rwen   (in_rwen),
      .in_pc     (in_pc),
      .flush     (flush),
      .mem       (mif.master),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_rwen  (out_rwen),
      .out_pc    (out_pc)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        rwen;
      logic [63:0] pc;
      int          vcyc;
   } item_t;

   item_t       q[$];
   int          st_cyc = -10;
   logic [63:0] st_wdata = '0;
   logic [7:0]  st_mask = '0;
   logic [63:0] last_addr = '0;

   task automatic model_reset();
      q.delete();
      st_cyc    = -10;
      last_addr = '0;
   endtask

   always @(negedge clock) begin : monitor
      bit    hold;
      bit    exp_rdy;
      item_t it;
      if (mon_en && !reset) begin
         hold    = (q.size() > 0) && (cyc >= q[0].vcyc);
         exp_rdy = !flush && ((q.size() == 0) || (hold && out_ready));
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, hold);
         chk("wvalid", mif.wvalid, st_cyc == cyc);
         chk("raddr", mif.raddr, last_addr);
         chk("waddr", mif.waddr, last_addr);
         if (hold) begin
            chk("out_data", out_data, q[0].data);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_rwen", out_rwen, q[0].rwen);
            chk("out_pc", out_pc, q[0].pc);
         end
         if (st_cyc == cyc) begin
            chk("wdata", mif.wdata, st_wdata);
            chk("wmask", mif.wmask, st_mask);
         end
         if (flush && q.size() > 0) void'(q.pop_front());
         else if (hold && out_ready) void'(q.pop_front());
         if (in_valid && exp_rdy) begin
            it.data = in_wen ? 64'd0
                    : in_ren ? ld_model(use_fixed ? fixed_rdata : rd_fn(in_addr), in_memop)
                    : in_addr;
            it.rd   = in_rd;
            it.rwen = in_rwen && !in_wen;
            it.pc   = in_pc;
            it.vcyc = cyc + ((in_ren || in_wen) ? 2 : 1);
            q.push_back(it);
            last_addr = in_addr;
            if (in_wen) begin
               st_cyc   = cyc + 1;
               st_wdata = in_wdata;
               st_mask  = 8'((1 << (1 << in_memop[1:0])) - 1);
            end
         end
      end
   end

   initial begin : rand_ctrl
      forever begin
         @(posedge clock);
         #1;
         if (rand_en) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if (flush) out_ready = 1'b0;
         end
      end
   end

   // Presents one instruction and returns at posedge+1 of the edge that accepted it.
   task automatic drive(input logic [63:0] a, input logic [63:0] wd, input logic r, input logic w,
                        input logic [2:0] op, input logic [4:0] rd, input logic rw, input logic [63:0] pc);
      int n;
      in_addr = a; in_wdata = wd; in_ren = r; in_wen = w;
      in_memop = op; in_rd = rd; in_rwen = rw; in_pc = pc;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clock);
         if (in_ready) begin
            @(posedge clock);
            #1;
            break;
         end
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: got no accept expected accept within 200 cycles");
            @(posedge clock);
            #1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin : main
      int pulses;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_wvalid", mif.wvalid, 1'b0);
      chk("rst_raddr", mif.raddr, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      reset = 1'b0;
      model_reset();
      mon_en = 1'b1;

      out_ready = 1'b1;
      drive(64'h1234, 64'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 64'h100);
      @(negedge clock);
      chk("add_valid", out_valid, 1'b1);
      chk("add_data", out_data, 64'h1234);
      chk("add_rwen", out_rwen, 1'b1);
      chk("add_wvalid", mif.wvalid, 1'b0);
      @(posedge clock); #1;

      use_fixed = 1'b1;
      fixed_rdata = 64'h0000_0000_0000_00F0;
      drive(64'h8000_0003, 64'd0, 1'b1, 1'b0, MEMOP_LB, 5'd6, 1'b1, 64'h104);
      @(negedge clock);
      chk("lb_access_valid", out_valid, 1'b0);
      @(negedge clock);
      chk("lb_valid", out_valid, 1'b1);
      chk("lb_data", out_data, 64'hFFFF_FFFF_FFFF_FFF0);
      @(posedge clock); #1;
      drive(64'h8000_0003, 64'd0, 1'b1, 1'b0, MEMOP_LBU, 5'd6, 1'b1, 64'h108);
      @(negedge clock);
      @(negedge clock);
      chk("lbu_data", out_data, 64'h0000_0000_0000_00F0);
      @(posedge clock); #1;
      use_fixed = 1'b0;

      drive(64'h8000_0004, 64'hDEAD_BEEF, 1'b0, 1'b1, MEMOP_LW, 5'd7, 1'b1, 64'h10C);
      @(negedge clock);
      chk("sw_wvalid", mif.wvalid, 1'b1);
      chk("sw_wmask", mif.wmask, 8'h0F);
      chk("sw_waddr", mif.waddr, 64'h8000_0004);
      chk("sw_wdata", mif.wdata, 64'hDEAD_BEEF);
      @(negedge clock);
      chk("sw_wvalid_end", mif.wvalid, 1'b0);
      chk("sw_out_valid", out_valid, 1'b1);
      chk("sw_out_rwen", out_rwen, 1'b0);
      chk("sw_out_data", out_data, 64'd0);
      @(posedge clock); #1;

      out_ready = 1'b0;
      drive(64'h55, 64'd0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1, 64'h110);
      in_addr = 64'h66; in_pc = 64'h114; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_data", out_data, 64'h55);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_accept", in_ready, 1'b1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_data", out_data, 64'h66);
      @(posedge clock); #1;

      drive(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, MEMOP_LD, 5'd2, 1'b1, 64'h118);
      flush = 1'b1;
      pulses = 0;
      @(negedge clock);
      pulses += int'(mif.wvalid);
      chk("fl_in_ready", in_ready, 1'b0);
      @(posedge clock); #1;
      flush = 1'b0;
      repeat (4) begin
         @(negedge clock);
         pulses += int'(mif.wvalid);
         chk("fl_out_valid", out_valid, 1'b0);
      end
      chk("fl_pulses", 64'(pulses), 64'd1);
      chk("fl_idle", in_ready, 1'b1);
      @(posedge clock); #1;

      mon_en = 1'b0;
      drive(64'h8000_0020, 64'hFACE, 1'b0, 1'b1, MEMOP_LD, 5'd3, 1'b1, 64'h11C);
      #2;
      chk("ar_wvalid_pre", mif.wvalid, 1'b1);
      reset = 1'b1;
      #1;
      chk("ar_wvalid", mif.wvalid, 1'b0);
      chk("ar_out_valid", out_valid, 1'b0);
      chk("ar_in_ready", in_ready, 1'b1);
      chk("ar_raddr", mif.raddr, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      mon_en = 1'b1;

      rand_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         logic [1:0] rw;
         logic [63:0] a;
         int gap;
         rw  = 2'($urandom_range(0, 3));
         a   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clock); #1;
         end
         drive(a, {$urandom, $urandom}, rw[0], rw[1], 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      end
      rand_en = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         @(posedge clock); #1;
      end
      mon_en = 1'b0;
      chk("drain_empty", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
